// File: rtl/vw_ext_pipe_if.sv
// Operand/extended-operand handshake bundle for vw_ext_pipe.
// The master drives operands and out_ready; the slave (the pipe) drives results and in_ready.
interface vw_ext_pipe_if #(
  parameter int unsigned NLANES = 4
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [32*NLANES-1:0]   a;
  logic [32*NLANES-1:0]   b;
  logic [32*NLANES-1:0]   c;
  logic [1:0]             vsew;
  logic [1:0]             widening;
  logic                   wide_b;
  logic [2:0]             signed_abc;
  logic [NLANES-1:0]      lane_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [32*NLANES-1:0]   ext_a;
  logic [32*NLANES-1:0]   ext_b;
  logic [32*NLANES-1:0]   ext_c;
  logic                   out_err;

  modport master (
    output flush, in_valid, a, b, c, vsew, widening, wide_b, signed_abc, lane_en, out_ready,
    input  in_ready, out_valid, ext_a, ext_b, ext_c, out_err
  );

  modport slave (
    input  flush, in_valid, a, b, c, vsew, widening, wide_b, signed_abc, lane_en, out_ready,
    output in_ready, out_valid, ext_a, ext_b, ext_c, out_err
  );
endinterface

// File: rtl/vw_ext_pipe.sv
// Multi-lane registered sign/zero-extension stage with a 2-entry output FIFO.
// Define VW_EXT_ERR_EN to flag and buffer illegal vsew/widening configurations on out_err.
module vw_ext_pipe #(
  parameter int unsigned NLANES = 4
) (
  input logic          clk,
  input logic          n_reset,
  vw_ext_pipe_if.slave bus
);
  localparam int unsigned W = 32 * NLANES;

  // Source width select: 0 = 8 b, 1 = 16 b, 2 = 32 b (passed unchanged)
  localparam logic [1:0] Sel8  = 2'd0;
  localparam logic [1:0] Sel16 = 2'd1;
  localparam logic [1:0] Sel32 = 2'd2;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sel,
                                         input logic sgn);
    logic [31:0] r;
    case (sel)
      Sel8:    r = {{24{sgn & v[7]}}, v[7:0]};
      Sel16:   r = {{16{sgn & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [1:0]   sel_a, sel_b, sel_c;
  logic [W-1:0] ext_a_d, ext_b_d, ext_c_d;

  always_comb begin
    sel_a = Sel32;
    sel_b = Sel32;
    sel_c = Sel32;
    case (bus.vsew)
      2'd0: begin
        sel_a = Sel8;
        sel_b = bus.wide_b ? Sel16 : Sel8;
        // widening[0] wins over widening[1]
        sel_c = bus.widening[0] ? Sel16 : (bus.widening[1] ? Sel32 : Sel8);
      end
      2'd1: begin
        sel_a = Sel16;
        sel_b = bus.wide_b ? Sel32 : Sel16;
        sel_c = bus.widening[0] ? Sel32 : Sel16;
      end
      default: ;
    endcase
  end

  always_comb begin
    ext_a_d = '0;
    ext_b_d = '0;
    ext_c_d = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (bus.lane_en[i]) begin
        ext_a_d[32*i +: 32] = extend(bus.a[32*i +: 32], sel_a, bus.signed_abc[0]);
        ext_b_d[32*i +: 32] = extend(bus.b[32*i +: 32], sel_b, bus.signed_abc[1]);
        ext_c_d[32*i +: 32] = extend(bus.c[32*i +: 32], sel_c, bus.signed_abc[2]);
      end
    end
  end

  logic [1:0]   count_q, count_d;
  logic         rd_q, rd_d, wr_q, wr_d;
  logic [W-1:0] mem_a_q [2];
  logic [W-1:0] mem_b_q [2];
  logic [W-1:0] mem_c_q [2];
  logic         push, pop;

  // in_ready depends only on registered count, so no out_ready -> in_ready path
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (bus.flush) begin
      count_d = 2'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      if (push) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
        mem_c_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push) begin
        mem_a_q[wr_q] <= ext_a_d;
        mem_b_q[wr_q] <= ext_b_d;
        mem_c_q[wr_q] <= ext_c_d;
      end
    end
  end

  assign bus.ext_a = mem_a_q[rd_q];
  assign bus.ext_b = mem_b_q[rd_q];
  assign bus.ext_c = mem_c_q[rd_q];

`ifdef VW_EXT_ERR_EN
  logic err_d;
  logic err_q [2];

  assign err_d = (bus.widening == 2'b11) | (bus.widening[1] & (bus.vsew != 2'd0)) |
                 (bus.vsew == 2'd3);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      err_q[0] <= 1'b0;
      err_q[1] <= 1'b0;
    end else if (push) begin
      err_q[wr_q] <= err_d;
    end
  end

  assign bus.out_err = err_q[rd_q];
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_vw_ext_pipe.sv
// Scoreboard bench for vw_ext_pipe: driver pushes reference-model results, monitor pops and compares.
module tb_vw_ext_pipe;
  localparam int NL = 4;
  localparam int W  = 32 * NL;

  typedef struct {
    logic [W-1:0]  a, b, c;
    logic [1:0]    vsew, widening;
    logic          wide_b;
    logic [2:0]    sgn;
    logic [NL-1:0] lane_en;
  } txn_t;

  typedef struct {
    logic [W-1:0] ea, eb, ec;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  vw_ext_pipe_if #(.NLANES(NL)) bus ();
  vw_ext_pipe #(.NLANES(NL)) dut (.clk(clk), .n_reset(n_reset), .bus(bus.slave));

  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Value of the low 'bits' bits of v, reinterpreted as signed if s, as a 32-bit pattern
  function automatic logic [31:0] ref_ext(input logic [31:0] v, input int bits, input bit s);
    longint x;
    if (bits >= 32) return v;
    x = longint'({32'd0, v}) % (longint'(1) << bits);
    if (s && x >= (longint'(1) << (bits - 1))) x = x - (longint'(1) << bits);
    return x[31:0];
  endfunction

  function automatic exp_t model(input txn_t t);
    exp_t e;
    int ba, bb, bc;
    ba = (t.vsew == 0) ? 8 : (t.vsew == 1) ? 16 : 32;
    if (t.vsew == 0)      bb = t.wide_b ? 16 : 8;
    else if (t.vsew == 1) bb = t.wide_b ? 32 : 16;
    else                  bb = 32;
    if (t.vsew == 0)      bc = t.widening[0] ? 16 : (t.widening[1] ? 32 : 8);
    else if (t.vsew == 1) bc = t.widening[0] ? 32 : 16;
    else                  bc = 32;
    e.ea = '0;
    e.eb = '0;
    e.ec = '0;
    for (int i = 0; i < NL; i++) begin
      if (t.lane_en[i]) begin
        e.ea[32*i +: 32] = ref_ext(t.a[32*i +: 32], ba, t.sgn[0]);
        e.eb[32*i +: 32] = ref_ext(t.b[32*i +: 32], bb, t.sgn[1]);
        e.ec[32*i +: 32] = ref_ext(t.c[32*i +: 32], bc, t.sgn[2]);
      end
    end
`ifdef VW_EXT_ERR_EN
    e.err = (t.widening == 2'b11) || (t.widening[1] && t.vsew != 0) || (t.vsew == 3);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  function automatic txn_t mk(input logic [1:0] vsew, input logic [1:0] wid, input logic wb,
                              input logic [2:0] sgn, input logic [NL-1:0] en,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    txn_t t;
    t.vsew = vsew; t.widening = wid; t.wide_b = wb; t.sgn = sgn; t.lane_en = en;
    t.a = {NL{a}}; t.b = {NL{b}}; t.c = {NL{c}};
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    for (int i = 0; i < NL; i++) begin
      t.a[32*i +: 32] = $urandom;
      t.b[32*i +: 32] = $urandom;
      t.c[32*i +: 32] = $urandom;
    end
    t.vsew = 2'($urandom_range(0, 3));
    t.widening = 2'($urandom_range(0, 3));
    t.wide_b = 1'($urandom_range(0, 1));
    t.sgn = 3'($urandom_range(0, 7));
    t.lane_en = ($urandom_range(0, 1) == 1) ? '1 : NL'($urandom);
    return t;
  endfunction

  // One clock: drive at posedge+1, model the edge at negedge+1 (after the monitor)
  task automatic step(input txn_t t, input bit v, input bit fl, input bit ordy, input bit rn,
                      output bit acc);
    bit pop;
    bus.a = t.a; bus.b = t.b; bus.c = t.c;
    bus.vsew = t.vsew; bus.widening = t.widening; bus.wide_b = t.wide_b;
    bus.signed_abc = t.sgn; bus.lane_en = t.lane_en;
    bus.in_valid = v; bus.flush = fl; bus.out_ready = ordy; n_reset = rn;
    @(negedge clk);
    #1;
    chk("in_ready", W'(bus.in_ready), W'(model_cnt < 2));
    chk("out_valid", W'(bus.out_valid), W'(model_cnt > 0));
    acc = rn && v && !fl && (model_cnt < 2);
    pop = (model_cnt > 0) && ordy;
    if (!rn || fl) begin
      model_cnt = 0;
      q.delete();
    end else begin
      model_cnt = model_cnt + int'(acc) - int'(pop);
      if (acc) q.push_back(model(t));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    txn_t t;
    t = mk(2'd0, 2'd0, 1'b0, 3'd0, '0, 32'd0, 32'd0, 32'd0);
    step(t, 1'b0, 1'b0, ordy, 1'b1, acc);
  endtask

  task automatic drain();
    repeat (4) idle(1'b1);
  endtask

  task automatic send(input txn_t t, input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      step(t, 1'b1, 1'b0, ordy, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got not-accepted want accepted");
    end
  endtask

  // Monitor: compare the head whenever the DUT presents it; pop on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got out_valid=1 want empty");
        end else begin
          e = q[0];
          chk("ext_a", bus.ext_a, e.ea);
          chk("ext_b", bus.ext_b, e.eb);
          chk("ext_c", bus.ext_c, e.ec);
          chk("out_err", W'(bus.out_err), W'(e.err));
          if (bus.out_ready === 1'b1) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t0, t1, t2;
    bit   acc;
    logic err6;
    n_reset = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.vsew = '0; bus.widening = '0;
    bus.wide_b = 1'b0; bus.signed_abc = '0; bus.lane_en = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_ext_a", bus.ext_a, '0);
    chk("rst_ext_b", bus.ext_b, '0);
    chk("rst_ext_c", bus.ext_c, '0);
    chk("rst_out_err", W'(bus.out_err), W'(0));
    idle(1'b0);
    idle(1'b0);

    // Basic signed 8-bit extension
    send(mk(2'd0, 2'd0, 1'b0, 3'b111, '1, 32'h80, 32'h7F, 32'hFF), 1'b0);
    chk("t2_ext_a", bus.ext_a, {NL{32'hFFFFFF80}});
    chk("t2_ext_b", bus.ext_b, {NL{32'h0000007F}});
    chk("t2_ext_c", bus.ext_c, {NL{32'hFFFFFFFF}});
    drain();

    // 2x widening of c, zero vs sign fill
    send(mk(2'd0, 2'b01, 1'b0, 3'b011, '1, 32'h1, 32'h2, 32'h0000_8001), 1'b0);
    chk("t3_zext_c", bus.ext_c, {NL{32'h00008001}});
    drain();
    send(mk(2'd0, 2'b01, 1'b0, 3'b111, '1, 32'h1, 32'h2, 32'h0000_8001), 1'b0);
    chk("t3_sext_c", bus.ext_c, {NL{32'hFFFF8001}});
    drain();

    // Back-pressure: third transaction stalls until a slot frees
    t0 = rnd(); t1 = rnd(); t2 = rnd();
    step(t0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(t1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(t2, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(t2, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    send(t2, 1'b1);
    drain();

    // Push+pop at count 1, then flush dropping a same-cycle push
    t0 = rnd(); t1 = rnd(); t2 = rnd();
    step(t0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(t1, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    step(t2, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b0);
    idle(1'b1);

    // Illegal widening at vsew=1 with masked lanes
    send(mk(2'd1, 2'b10, 1'b0, 3'b111, 4'b0101, 32'h5, 32'h6, 32'h1234_8001), 1'b0);
    chk("t6_ext_c", bus.ext_c, {32'h0, 32'hFFFF8001, 32'h0, 32'hFFFF8001});
    chk("t6_ext_a_masked", bus.ext_a, {32'h0, 32'h5, 32'h0, 32'h5});
`ifdef VW_EXT_ERR_EN
    err6 = 1'b1;
`else
    err6 = 1'b0;
`endif
    chk("t6_out_err", W'(bus.out_err), W'(err6));
    drain();

    // Reset mid-operation discards buffered data
    step(rnd(), 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(rnd(), 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(rnd(), 1'b1, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);

    // Randomised traffic with occasional flushes and back-pressure
    for (int k = 0; k < 600; k++) begin
      step(rnd(), 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) != 0), 1'b1, acc);
    end

    repeat (6) idle(1'b1);
    chk("final_queue_empty", W'(q.size()), W'(0));
    chk("final_out_valid", W'(bus.out_valid), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
